// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: triangle count between latched lo/hi for N round trips.
// Define SWEEP_DWELL_EN to add a one-cycle dwell at each reversal point.
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int TRIPS_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [TRIPS_W-1:0] trips,
    input  logic               hold,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UP    = 3'd1,
        S_DOWN  = 3'd2,
`ifdef SWEEP_DWELL_EN
        S_DWELL = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0]   C_ONE = WIDTH'(1);
    localparam logic [TRIPS_W-1:0] T_ONE = TRIPS_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [TRIPS_W-1:0] trips_q, trips_d;
    logic [TRIPS_W-1:0] trip_cnt_q, trip_cnt_d;
    logic [TRIPS_W-1:0] trip_nxt;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            dir_q      <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            trips_q    <= '0;
            trip_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            trips_q    <= trips_d;
            trip_cnt_q <= trip_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dir_d      = dir_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        trips_d    = trips_q;
        trip_cnt_d = trip_cnt_q;
        err_d      = 1'b0;
        trip_nxt   = trip_cnt_q + T_ONE;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // lo<hi is what guarantees the count never wraps
                    if (lo >= hi || trips == '0) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d       = lo;
                        hi_d       = hi;
                        trips_d    = trips;
                        count_d    = lo;
                        trip_cnt_d = '0;
                        dir_d      = 1'b0;
                        state_d    = S_UP;
                    end
                end
            end
            S_UP: begin
                if (!hold) begin
                    if (count_q < hi_q) begin
                        count_d = count_q + C_ONE;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        state_d = S_DWELL;
`else
                        state_d = S_DOWN;
                        dir_d   = 1'b1;
                        count_d = hi_q - C_ONE;
`endif
                    end
                end
            end
            S_DOWN: begin
                if (!hold) begin
                    if (count_q > lo_q) begin
                        count_d = count_q - C_ONE;
                    end else begin
                        trip_cnt_d = trip_nxt;
                        if (trip_nxt == trips_q) begin
                            state_d = S_DONE;
                            dir_d   = 1'b0;
                        end else begin
`ifdef SWEEP_DWELL_EN
                            state_d = S_DWELL;
`else
                            state_d = S_UP;
                            dir_d   = 1'b0;
                            count_d = lo_q + C_ONE;
`endif
                        end
                    end
                end
            end
`ifdef SWEEP_DWELL_EN
            S_DWELL: begin
                // dir still holds the direction we arrived in
                if (!hold) begin
                    if (!dir_q) begin
                        state_d = S_DOWN;
                        dir_d   = 1'b1;
                        count_d = hi_q - C_ONE;
                    end else begin
                        state_d = S_UP;
                        dir_d   = 1'b0;
                        count_d = lo_q + C_ONE;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign err   = err_q;
    assign done  = (state_q == S_DONE);
`ifdef SWEEP_DWELL_EN
    assign busy  = (state_q == S_UP) || (state_q == S_DOWN) ||
                   (state_q == S_DWELL);
`else
    assign busy  = (state_q == S_UP) || (state_q == S_DOWN);
`endif

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: vector table, directed
// corner sequences, and randomized traffic against a trace-based model.
module tb_updown_sweep_ctrl;

    localparam int W  = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [W-1:0]  lo = '0;
    logic [W-1:0]  hi = '0;
    logic [TW-1:0] trips = '0;
    logic [W-1:0]  count;
    logic          dir, busy, done, err;

    always #5 clk = ~clk;

    updown_sweep_ctrl #(.WIDTH(W), .TRIPS_W(TW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .lo    (lo),
        .hi    (hi),
        .trips (trips),
        .hold  (hold),
        .count (count),
        .dir   (dir),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    function automatic int outs();
        return (int'(count) << 4) | (int'(dir) << 3) | (int'(busy) << 2) |
               (int'(done) << 1) | int'(err);
    endfunction

    function automatic int pack(int c, bit d, bit b, bit dn, bit e);
        return (c << 4) | (int'(d) << 3) | (int'(b) << 2) |
               (int'(dn) << 1) | int'(e);
    endfunction

    // Expected edges from accepted start to the done pulse
    function automatic int exp_lat(int l, int h, int t);
`ifdef SWEEP_DWELL_EN
        return 2 * (h - l) * t + 2 * t;
`else
        return 2 * (h - l) * t + 1;
`endif
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit r; bit s; bit h;
        int l; int hh; int t;
        int c; bit d; bit b; bit dn; bit e;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit r, bit s, bit h, int l, int hh, int t,
                                int c, bit d, bit b, bit dn, bit e);
        vec_t v;
        v.r = r; v.s = s; v.h = h; v.l = l; v.hh = hh; v.t = t;
        v.c = c; v.d = d; v.b = b; v.dn = dn; v.e = e;
        tbl.push_back(v);
    endfunction

    function automatic void fill_table();
`ifdef SWEEP_DWELL_EN
        add(1,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,0, 1,3,1, 1,0,1,0,0);
        add(0,0,0, 0,0,0, 2,0,1,0,0);
        add(0,0,0, 0,0,0, 3,0,1,0,0);
        add(0,0,0, 0,0,0, 3,0,1,0,0);
        add(0,1,0, 0,3,1, 2,1,1,0,0);
        add(0,1,0, 0,3,1, 1,1,1,0,0);
        add(0,0,0, 0,0,0, 1,0,0,1,0);
        add(0,0,0, 0,0,0, 1,0,0,0,0);
        add(0,1,0, 5,5,1, 1,0,0,0,1);
        add(0,1,0, 0,3,0, 1,0,0,0,1);
        add(0,0,0, 0,0,0, 1,0,0,0,0);
`else
        add(1,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,0, 2,5,1, 2,0,1,0,0);
        add(0,0,0, 0,0,0, 3,0,1,0,0);
        add(0,0,0, 0,0,0, 4,0,1,0,0);
        add(0,0,0, 0,0,0, 5,0,1,0,0);
        add(0,0,0, 0,0,0, 4,1,1,0,0);
        add(0,0,0, 0,0,0, 3,1,1,0,0);
        add(0,0,0, 0,0,0, 2,1,1,0,0);
        add(0,0,0, 0,0,0, 2,0,0,1,0);
        add(0,0,0, 0,0,0, 2,0,0,0,0);
        add(0,1,0, 5,5,1, 2,0,0,0,1);
        add(0,1,0, 6,3,1, 2,0,0,0,1);
        add(0,1,0, 0,3,0, 2,0,0,0,1);
        add(0,0,0, 0,0,0, 2,0,0,0,0);
        add(0,1,0, 0,2,1, 0,0,1,0,0);
        add(0,1,0, 9,3,0, 1,0,1,0,0);
        add(0,0,1, 0,0,0, 1,0,1,0,0);
        add(0,0,1, 0,0,0, 1,0,1,0,0);
        add(0,0,0, 0,0,0, 2,0,1,0,0);
        add(0,0,0, 0,0,0, 1,1,1,0,0);
        add(0,0,0, 0,0,0, 0,1,1,0,0);
        add(0,1,0, 1,4,1, 0,0,0,1,0);
        add(0,1,0, 1,4,1, 0,0,0,0,0);
        add(0,1,0, 1,4,1, 1,0,1,0,0);
        add(1,0,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0,0,0,0);
`endif
    endfunction

    // ---------------- directed sweep helper ----------------
    task automatic run_sweep(input int l, input int h, input int t,
                             input int hv, input int hn,
                             output int lat, output int peaks,
                             output bit oob, output bit saw_done);
        int held = 0;
        int prev;
        @(negedge clk);
        lo = W'(l); hi = W'(h); trips = TW'(t); start = 1'b1; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; peaks = 0; oob = 1'b0;
        prev = int'(count);
        while (!done && lat < 600) begin
            @(negedge clk);
            hold = (hv >= 0 && int'(count) == hv && !dir && held < hn);
            if (hold) held++;
            @(posedge clk); #1;
            lat++;
            if (int'(count) < l || int'(count) > h) oob = 1'b1;
            if (int'(count) == h && prev != h) peaks++;
            prev = int'(count);
        end
        saw_done = done;
        @(negedge clk);
        hold = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct { int c; bit d; bit b; bit dn; } ent_t;
    ent_t mtr[$];
    bit   m_run;
    int   m_idx;
    int   m_idle_c;
    bit   m_err;

    function automatic void build_trace(int l, int h, int t);
        mtr.delete();
        for (int k = 0; k < t; k++) begin
            for (int v = (k == 0) ? l : l + 1; v <= h; v++)
                mtr.push_back('{v, 1'b0, 1'b1, 1'b0});
`ifdef SWEEP_DWELL_EN
            mtr.push_back('{h, 1'b0, 1'b1, 1'b0});
`endif
            for (int v = h - 1; v >= l; v--)
                mtr.push_back('{v, 1'b1, 1'b1, 1'b0});
`ifdef SWEEP_DWELL_EN
            if (k < t - 1) mtr.push_back('{l, 1'b1, 1'b1, 1'b0});
`endif
        end
        mtr.push_back('{l, 1'b0, 1'b0, 1'b1});
    endfunction

    function automatic void model_step();
        m_err = 1'b0;
        if (rst) begin
            m_run = 1'b0;
            m_idle_c = 0;
        end else if (m_run) begin
            if (mtr[m_idx].dn) begin
                m_run = 1'b0;
                m_idle_c = mtr[m_idx].c;
            end else if (!hold) begin
                m_idx++;
            end
        end else if (start) begin
            if (lo >= hi || trips == '0) begin
                m_err = 1'b1;
            end else begin
                build_trace(int'(lo), int'(hi), int'(trips));
                m_idx = 0;
                m_run = 1'b1;
            end
        end
    endfunction

    function automatic int model_outs();
        if (m_run)
            return pack(mtr[m_idx].c, mtr[m_idx].d, mtr[m_idx].b,
                        mtr[m_idx].dn, m_err);
        return pack(m_idle_c, 1'b0, 1'b0, 1'b0, m_err);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int lat, peaks, n;
        bit oob, sd, seen;

        fill_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r; start = tbl[i].s; hold = tbl[i].h;
            lo = W'(tbl[i].l); hi = W'(tbl[i].hh); trips = TW'(tbl[i].t);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), outs(),
                pack(tbl[i].c, tbl[i].d, tbl[i].b, tbl[i].dn, tbl[i].e));
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; hold = 1'b0;
        @(posedge clk); #1;

        // full-range sweep: two peaks at 15, no wrap
        run_sweep(0, 15, 2, -1, 0, lat, peaks, oob, sd);
        chk("full_done_seen", int'(sd), 1);
        chk("full_latency", lat, exp_lat(0, 15, 2));
        chk("full_peaks", peaks, 2);
        chk("full_in_range", int'(oob), 0);

        // hold for 3 cycles at count=4 while rising
        run_sweep(2, 6, 1, 4, 3, lat, peaks, oob, sd);
        chk("hold_done_seen", int'(sd), 1);
        chk("hold_latency", lat, exp_lat(2, 6, 1) + 3);
        chk("hold_in_range", int'(oob), 0);

        // reset mid-sweep while descending through 3
        @(negedge clk);
        lo = 4'd1; hi = 4'd5; trips = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(count == 4'd3 && dir) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reach_down3", int'(n < 50), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_state", outs(), pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("rst_no_done", int'(seen), 0);
        run_sweep(2, 4, 1, -1, 0, lat, peaks, oob, sd);
        chk("post_rst_sweep", lat, exp_lat(2, 4, 1));

        // randomized traffic against the trace model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst   = (c == 0) || ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 5) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            lo    = W'($urandom_range(0, 15));
            hi    = W'($urandom_range(0, 15));
            trips = TW'($urandom_range(0, 3));
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rand%0d", c), outs(), model_outs());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
